// File: rtl/rom_window_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency ROM among NREQ
// requesters. Each requester addresses a private WINDOW-byte slice of the ROM
// at physical base g*WINDOW. Out-of-window local addresses are answered with
// err and zero data without touching the ROM.
//
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   req         - per-requester read request, held until its ack
//   addr_bus    - packed local addresses, requester i at [AW*i +: AW]
//   ack, err    - one-cycle pulses to the served requester
//   rdata       - read data, held until the next ack
//   grant_id    - index of the requester being served
//   busy        - high whenever the FSM is not idle
//   rom_en      - one-cycle ROM read strobe
//   rom_addr    - physical ROM address, valid while rom_en is high
//   rom_data    - ROM read data, valid the cycle after rom_en
module rom_window_arbiter #(
  parameter int unsigned NREQ      = 8,
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned WINDOW    = 25,
  parameter int unsigned ROM_DEPTH = 200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*AW-1:0]        addr_bus,
  output logic [NREQ-1:0]           ack,
  output logic [NREQ-1:0]           err,
  output logic [DW-1:0]             rdata,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      rom_en,
  output logic [AW-1:0]             rom_addr,
  input  logic [DW-1:0]             rom_data
);

  localparam int unsigned GW = $clog2(NREQ);
  // One bit of headroom so the offset sum never wraps
  localparam int unsigned PW = $clog2(ROM_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_last_grant;

  logic            w_found;
  logic [GW-1:0]   w_grant;
  logic [GW-1:0]   w_idx;
  logic [AW-1:0]   w_addr;
  logic [PW-1:0]   w_phys;
  logic            w_addr_bad;

  // Round-robin pick: first pending request after the last grant
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = GW'((32'(r_last_grant) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Local address of the winner and its physical ROM location
  always_comb begin
    w_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant == GW'(i)) begin
        w_addr = addr_bus[i*AW +: AW];
      end
    end
    w_phys     = PW'(w_addr) + PW'(w_grant) * PW'(WINDOW);
    w_addr_bad = (PW'(w_addr) >= PW'(WINDOW));
  end

  // Access FSM; ack/err/rom_en default low so they pulse for one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= GW'(NREQ - 1);
      ack          <= '0;
      err          <= '0;
      rdata        <= '0;
      grant_id     <= '0;
      busy         <= 1'b0;
      rom_en       <= 1'b0;
      rom_addr     <= '0;
    end else begin
      ack    <= '0;
      err    <= '0;
      rom_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            grant_id     <= w_grant;
            r_last_grant <= w_grant;
            busy         <= 1'b1;
            if (w_addr_bad) begin
              // Out-of-window: answer immediately, ROM untouched
              rdata   <= '0;
              ack     <= NREQ'(1) << w_grant;
              err     <= NREQ'(1) << w_grant;
              r_state <= S_ACK;
            end else begin
              rom_en   <= 1'b1;
              rom_addr <= AW'(w_phys);
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          rdata   <= rom_data;
          ack     <= NREQ'(1) << grant_id;
          r_state <= S_ACK;
        end
        S_ACK: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_window_arbiter.sv
// Directed bench for rom_window_arbiter: single accesses, window boundaries,
// error path, full round-robin sweep, two-requester alternation and reset
// during an access. A small registered ROM model supplies rom_data.
module tb_rom_window_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  req = '0;
  logic [63:0] addr_bus = '0;
  logic [7:0]  ack;
  logic [7:0]  err;
  logic [7:0]  rdata;
  logic [2:0]  grant_id;
  logic        busy;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  rom_window_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .addr_bus (addr_bus),
    .ack      (ack),
    .err      (err),
    .rdata    (rdata),
    .grant_id (grant_id),
    .busy     (busy),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  // ROM contents: odd multiplier keeps every location distinct
  function automatic logic [7:0] rom_val(input logic [7:0] a);
    return (a * 8'd37) ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_val(rom_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated access; entered at a negedge with the DUT idle
  task automatic single(input int g, input logic [7:0] a, input logic [7:0] exp_phys,
                        input logic exp_err, input string tag);
    logic [7:0] oh;
    oh = 8'(1) << g;
    req = '0;
    req[g] = 1'b1;
    addr_bus[8*g +: 8] = a;
    @(negedge clk);
    check({tag, "_grant"}, 32'(grant_id), 32'(g));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (exp_err) begin
      check({tag, "_ack"}, 32'(ack), 32'(oh));
      check({tag, "_err"}, 32'(err), 32'(oh));
      check({tag, "_rdata"}, 32'(rdata), 32'd0);
      check({tag, "_romen"}, 32'(rom_en), 32'd0);
    end else begin
      check({tag, "_romen"}, 32'(rom_en), 32'd1);
      check({tag, "_romaddr"}, 32'(rom_addr), 32'(exp_phys));
      check({tag, "_ack_early"}, 32'(ack), 32'd0);
      @(negedge clk);
      check({tag, "_romen_off"}, 32'(rom_en), 32'd0);
      check({tag, "_ack_early2"}, 32'(ack), 32'd0);
      @(negedge clk);
      check({tag, "_ack"}, 32'(ack), 32'(oh));
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_rdata"}, 32'(rdata), 32'(rom_val(exp_phys)));
    end
    req = '0;
    @(negedge clk);
    check({tag, "_ack_off"}, 32'(ack), 32'd0);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_romen_idle"}, 32'(rom_en), 32'd0);
  endtask

  // Wait (bounded) for the next ack; check its spacing, target and data
  task automatic wait_ack(input string tag, input logic [7:0] exp_ack, input int exp_cyc,
                          input logic [7:0] exp_rdata);
    int c;
    int i;
    c = 0;
    i = 0;
    while (c == 0 && i < 12) begin
      @(negedge clk);
      i++;
      if (ack != 8'h00) c = i;
    end
    check({tag, "_cyc"}, 32'(c), 32'(exp_cyc));
    check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_romen", 32'(rom_en), 32'd0);
    check("rst_romaddr", 32'(rom_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single accesses, window bases/ends, and the out-of-window error path
    single(0, 8'd3,  8'd3,   1'b0, "t1_r0a3");
    single(2, 8'd0,  8'd50,  1'b0, "t2_r2a0");
    single(7, 8'd24, 8'd199, 1'b0, "t2_r7a24");
    single(3, 8'd25, 8'd0,   1'b1, "t5_r3a25");
    single(6, 8'd255, 8'd0,  1'b1, "t5_r6a255");
    single(1, 8'd10, 8'd35,  1'b0, "t2_r1a10");

    // All requesters held from reset: 0..7 then 0 again, 4 cycles apart
    reset = 1'b1;
    addr_bus = '0;
    @(negedge clk);
    req = 8'hFF;
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wait_ack($sformatf("t3_k%0d", k), 8'(1) << (k % 8), (k == 0) ? 3 : 4,
               rom_val(8'((k % 8) * 25)));
    end

    // Two held requesters alternate, never the same one twice in a row
    req = 8'h22;
    wait_ack("t4_a", 8'h02, 4, rom_val(8'd25));
    wait_ack("t4_b", 8'h20, 4, rom_val(8'd125));
    wait_ack("t4_c", 8'h02, 4, rom_val(8'd25));
    wait_ack("t4_d", 8'h20, 4, rom_val(8'd125));
    req = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset during ISSUE for requester 4
    req = 8'h10;
    addr_bus[39:32] = 8'd5;
    @(negedge clk);
    check("t6_issue_romen", 32'(rom_en), 32'd1);
    check("t6_issue_addr", 32'(rom_addr), 32'd105);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_romen", 32'(rom_en), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ack", 32'(ack), 32'd0);
    check("t6_rst_grant", 32'(grant_id), 32'd0);
    check("t6_rst_romaddr", 32'(rom_addr), 32'd0);
    check("t6_rst_rdata", 32'(rdata), 32'd0);
    req = '0;
    @(negedge clk);
    check("t6_noack", 32'(ack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    addr_bus = '0;
    req = 8'h11;
    wait_ack("t6_first", 8'h01, 3, rom_val(8'd0));
    wait_ack("t6_second", 8'h10, 4, rom_val(8'd100));
    req = '0;
    repeat (2) @(negedge clk);
    check("t6_end_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
